// File: rtl/fir_audio_pkg.sv
// fir_audio_pkg: shared constants, sample type and I2S transmitter state encoding
package fir_audio_pkg;
   localparam int SAMPLE_W = 24;
   localparam int SLOT_W   = 32;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef enum logic {IDLE, RUN} i2s_state_t;
endpackage

// File: rtl/fir_i2s_fifo.sv
// fir_i2s_fifo: 2-entry synchronous FIFO buffering FIR samples ahead of the I2S serializer
module fir_i2s_fifo
   import fir_audio_pkg::*;
#(
   parameter int W = SAMPLE_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;
   logic         w_wr;
   logic         w_rd;

   assign full    = (r_cnt == 2'd2);
   assign empty   = (r_cnt == 2'd0);
   assign w_wr    = wr_en && !full;
   assign w_rd    = rd_en && !empty;
   assign rd_data = r_mem[r_rp];

   // pointer/occupancy update; a pop of an empty FIFO is ignored, a full FIFO refuses writes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_wr) begin
            r_mem[r_wp] <= wr_data;
            r_wp        <= ~r_wp;
         end
         if (w_rd) r_rp <= ~r_rp;
         r_cnt <= r_cnt + 2'(w_wr) - 2'(w_rd);
      end
   end
endmodule

// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: FIR output to I2S DAC link; mono sample sent in both slots.
// Build option FIR_I2S_ZERO_FILL_EN: underrun frames carry silence instead of the last sample.
module fir_i2s_tx #(
   parameter int DATA_W   = fir_audio_pkg::SAMPLE_W,
   parameter int SLOT_W   = fir_audio_pkg::SLOT_W,
   parameter int BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              bclk,
   output logic              lrck,
   output logic              sdata,
   output logic              underrun
);
   import fir_audio_pkg::*;

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
   localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);

   i2s_state_t        r_state;
   i2s_state_t        w_state_nxt;
   logic [DIV_W-1:0]  r_div;
   logic [BIT_W-1:0]  r_bit;
   logic [BIT_W-1:0]  w_bit_nxt;
   logic [BIT_W-1:0]  w_pos;
   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] r_last;
   logic [DATA_W-1:0] w_fill;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W:0]   w_shl;
   logic              r_bclk;
   logic              r_lrck;
   logic              r_sdata;
   logic              r_underrun;
   logic              r_started;
   logic              w_full;
   logic              w_empty;
   logic              w_wr;
   logic              w_wrap;
   logic              w_fall;
   logic              w_bit_wrap;
   logic              w_frame;

   fir_i2s_fifo #(.W(DATA_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_wr),
      .wr_data (sample_in),
      .rd_en   (w_frame),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty)
   );

`ifdef FIR_I2S_ZERO_FILL_EN
   assign w_fill = '0;
`else
   assign w_fill = r_last;
`endif

   assign w_wr         = sample_valid && !w_full;
   assign sample_ready = !w_full;
   assign bclk         = r_bclk;
   assign lrck         = r_lrck;
   assign sdata        = r_sdata;
   assign underrun     = r_underrun;

   // the very first fall event after leaving IDLE opens frame 0 without advancing the counter
   assign w_wrap     = (r_state == RUN) && (r_div == DIV_LAST);
   assign w_fall     = w_wrap && r_bclk;
   assign w_bit_wrap = !r_started || (r_bit == BIT_LAST);
   assign w_bit_nxt  = w_bit_wrap ? '0 : r_bit + 1'b1;
   assign w_frame    = w_fall && w_bit_wrap;
   assign w_pos      = (w_bit_nxt >= SLOT_B) ? w_bit_nxt - SLOT_B : w_bit_nxt;
   // position p selects word[DATA_W-p]; p=0 and p>DATA_W fall onto zero padding
   assign w_shl      = {1'b0, r_word} << w_pos;

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // leave IDLE once a sample is buffered; RUN is only left through reset
   always_comb begin
      w_state_nxt = (r_state == IDLE && !w_empty) ? RUN : r_state;
   end

   // bclk divider, frozen at zero while IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (r_state == RUN) begin
         r_div  <= w_wrap ? '0 : r_div + 1'b1;
         r_bclk <= r_bclk ^ w_wrap;
      end
   end

   // bit counter, word select, serial data and frame-start word load, all on fall events
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit      <= '0;
         r_started  <= 1'b0;
         r_lrck     <= 1'b0;
         r_sdata    <= 1'b0;
         r_underrun <= 1'b0;
         r_word     <= '0;
         r_last     <= '0;
      end else begin
         r_underrun <= w_frame && w_empty;
         if (w_fall) begin
            r_bit     <= w_bit_nxt;
            r_started <= 1'b1;
            r_lrck    <= (w_bit_nxt >= SLOT_B);
            r_sdata   <= w_shl[DATA_W];
         end
         if (w_frame) begin
            r_word <= w_empty ? w_fill : w_rd_data;
            if (!w_empty) r_last <= w_rd_data;
         end
      end
   end
endmodule

// File: tb/tb_fir_i2s_tx.sv
// tb_fir_i2s_tx: randomized self-checking bench; a queue-level model predicts ready/underrun and frame words
module tb_fir_i2s_tx;
   localparam int DATA_W   = 24;
   localparam int SLOT_W   = 32;
   localparam int BCLK_DIV = 4;
   localparam int FRAME    = 2 * SLOT_W * 2 * BCLK_DIV;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              sample_valid = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_ready;
   logic              bclk;
   logic              lrck;
   logic              sdata;
   logic              underrun;

   fir_i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .bclk         (bclk),
      .lrck         (lrck),
      .sdata        (sdata),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] frames[$];
   logic [DATA_W-1:0] last_w;
   logic [DATA_W-1:0] mon_acc;
   longint            cyc;
   longint            t_first;
   bit                started;
   bit                exp_und;
   bit                acc;
   bit                prev_bclk;
   bit                mon_pad;
   bit                mon_p0;
   bit                rise_now;
   int                rises;
   int                last_b;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   // advance one clock: update the model with the inputs seen at the edge, then compare outputs
   task automatic tick();
      logic [DATA_W-1:0] w;
      int b, f, p;
      @(negedge clk);
      exp_und  = 1'b0;
      acc      = 1'b0;
      rise_now = 1'b0;
      if (reset) begin
         q.delete();
         frames.delete();
         last_w    = '0;
         started   = 1'b0;
         cyc       = 0;
         rises     = 0;
         prev_bclk = 1'b0;
         check("rst_bclk", bclk, 0);
         check("rst_lrck", lrck, 0);
         check("rst_sdata", sdata, 0);
      end else begin
         acc = sample_valid && (q.size() < 2);
         if (started && cyc >= t_first && (cyc - t_first) % FRAME == 0) begin
            if (q.size() > 0) begin
               w = q.pop_front();
               last_w = w;
            end else begin
`ifdef FIR_I2S_ZERO_FILL_EN
               w = '0;
`else
               w = last_w;
`endif
               exp_und = 1'b1;
            end
            frames.push_back(w);
         end
         if (acc) begin
            q.push_back(sample_in);
            if (!started) begin
               started = 1'b1;
               t_first = cyc + 1 + 2 * BCLK_DIV;
            end
         end
         cyc++;
         if (!started) begin
            check("idle_bclk", bclk, 0);
            check("idle_lrck", lrck, 0);
            check("idle_sdata", sdata, 0);
         end
         if (bclk && !prev_bclk) begin
            rise_now = 1'b1;
            if (rises == 0) begin
               check("first_rise_late", ((cyc - 1) - (t_first - 1 - 2 * BCLK_DIV)) <= 2 * BCLK_DIV, 1);
               check("pre_frame_sdata", sdata, 0);
            end else begin
               b = (rises - 1) % (2 * SLOT_W);
               f = (rises - 1) / (2 * SLOT_W);
               p = b % SLOT_W;
               last_b = b;
               if (p == 0) begin
                  check("lrck_slot_start", lrck, b >= SLOT_W);
                  mon_acc = '0;
                  mon_pad = 1'b0;
                  mon_p0  = sdata;
               end else if (p <= DATA_W) begin
                  mon_acc = {mon_acc[DATA_W-2:0], sdata};
               end else begin
                  mon_pad = mon_pad | sdata;
               end
               if (p == SLOT_W - 1) begin
                  check("lrck_slot_end", lrck, b >= SLOT_W);
                  check("slot_padding", {mon_p0, mon_pad}, 0);
                  if (f < frames.size()) check(b >= SLOT_W ? "right_word" : "left_word", mon_acc, frames[f]);
                  else check("frame_missing", 0, 1);
               end
            end
            rises++;
         end
         prev_bclk = bclk;
      end
      check("ready", sample_ready, q.size() < 2);
      check("underrun", underrun, exp_und);
   endtask

   task automatic idle(input int n);
      sample_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic write1(input logic [DATA_W-1:0] d);
      sample_in    = d;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   initial begin
      int rate;
      bit hit;
      do_reset();
      do_reset();
      idle(100);

      write1(24'hA53C81);
      idle(2 * FRAME + 200);

      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         tick();
         hit = rise_now && last_b == 40;
      end
      check("reach_bit40", hit, 1);
      do_reset();
      idle(20);
      write1(24'h5E_0F_17);
      idle(FRAME + 100);

      do_reset();
      write1(24'h000123);
      idle(FRAME + 100);
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         hit = started && (cyc - t_first) % FRAME == 0;
         if (!hit) tick();
      end
      check("reach_frame_edge", hit, 1);
      write1(24'h0ABCDE);
      check("sim_pop_write_underrun", exp_und, 1);
      idle(2 * FRAME + 100);

      do_reset();
      sample_in    = 24'd1;
      sample_valid = 1'b1;
      for (int i = 0; i < 4 * FRAME; i++) begin
         tick();
         if (acc) sample_in = sample_in + 1'b1;
      end
      sample_valid = 1'b0;
      idle(FRAME);

      do_reset();
      rate = 0;
      for (int i = 0; i < 8 * FRAME; i++) begin
         if (i % FRAME == 0) rate = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
         if (!sample_valid || acc) begin
            sample_valid = $urandom_range(0, 999) < rate;
            sample_in    = DATA_W'($urandom);
         end
         tick();
      end
      idle(2 * FRAME);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fir_i2s_tx.md
Name: fir_i2s_tx

Overview:
- Downstream stage of the FIR filter.
- Accepts the filter's 24-bit output samples through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Serializes each sample onto an I2S link (bclk, lrck, sdata) to the audio codec DAC. The mono sample is duplicated into the left and right slots.
- All timing is derived from the single system clock through enable-based division; no derived clocks are used internally.

Parameters:
- DATA_W, 24, sample width; must equal the FIR output width.
- SLOT_W, 32, bclk periods per channel slot; must be ≥ DATA_W+1.
- BCLK_DIV, 4, clk cycles per bclk half-period; must be ≥ 1. bclk period = 2*BCLK_DIV clk cycles.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- sample_in  in  DATA_W  signed two's-complement sample from the FIR.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample.
- bclk  out  1  I2S bit clock, registered.
- lrck  out  1  I2S word select: 0 = left slot, 1 = right slot. Registered.
- sdata  out  1  I2S serial data, MSB first. Registered.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.

Behaviour:
- Reset values: bclk=0, lrck=0, sdata=0, underrun=0, sample_ready=1. FIFO is flushed, counters are cleared, last-sample register is 0, state = IDLE.
- Reset asserted mid-frame: all of the above apply on the next clk edge. No partial bit is completed.
- Handshake:
  - Write occurs when sample_valid && sample_ready.
  - sample_ready = !fifo_full, registered view.
  - When full, sample_valid is ignored; the sample is neither dropped silently nor stored, so the upstream must hold it.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - At wrap, bclk toggles.
  - A 1→0 toggle is a "fall event"; a 0→1 toggle is a "rise event".
- State machine:
  - IDLE: div_cnt is held at 0 and bclk=0. Goes to RUN in the cycle after the FIFO becomes non-empty.
  - RUN: the divider runs freely.
  - RUN never returns to IDLE except by reset.
- Bit counter: bit_cnt (0..2*SLOT_W-1) advances on every fall event.
  - lrck = (bit_cnt >= SLOT_W).
  - Slot position p = bit_cnt mod SLOT_W.
- Frame start: the fall event at which bit_cnt becomes 0, including the first fall event after entering RUN.
  - If the FIFO is non-empty: pop into word_reg and also copy it to last_sample.
  - If the FIFO is empty: pulse underrun for one cycle and load word_reg per the Optional Feature.
- Serial data: sdata is updated on fall events only.
  - sdata = word_reg[DATA_W-p] for 1 ≤ p ≤ DATA_W.
  - sdata = 0 for p = 0 and p > DATA_W. This is the standard I2S one-bit delay.
  - The same word is used in both slots.
  - The codec samples on rise events; sdata is stable for ≥ BCLK_DIV clk cycles around each rise event.
- Simultaneous write and pop:
  - FIFO empty: the pop sees empty, underrun fires, and the written sample is stored. No bypass.
  - FIFO full: the write is blocked by sample_ready=0; the pop proceeds, and sample_ready=1 on the next cycle.
- Throughput: one sample per 2*SLOT_W*2*BCLK_DIV clk cycles (512 at defaults).

Optional Feature:
- Macro: FIR_I2S_ZERO_FILL_EN.
- Defined: on underrun, word_reg is loaded with 0 (silence).
- Undefined: on underrun, word_reg is reloaded with last_sample (hold last value).
- The underrun pulse is identical in both builds.

Decomposition:
- Shared package fir_audio_pkg:
  - SAMPLE_W=24 and SLOT_W=32 constants.
  - sample_t typedef (signed [SAMPLE_W-1:0]).
  - i2s_state_t enum {IDLE, RUN}.
- Sub-module fir_i2s_fifo: 2-entry synchronous FIFO.
  - Inputs: wr_en/wr_data, rd_en.
  - Outputs: rd_data, full, empty.
  - Shares clk and reset with the parent.
- Divider, bit counter and shifter stay in fir_i2s_tx.

Test Plan:
- Reset then idle: no sample_valid for 100 cycles → bclk=0, lrck=0, sdata=0, sample_ready=1, underrun=0 throughout.
- Single sample 24'hA5_3C_81 written: first bclk rise within 2*BCLK_DIV cycles; left slot bits p=1..24 read as 0xA53C81, p=25..31 read as 0, p=0 reads as 0; right slot is identical.
- Backpressure: hold sample_valid=1 with incrementing data (1,2,3,…) from reset → sample_ready deasserts after 2 accepts (3 if a pop intervened); frames carry 1,2,3,… in order with none lost.
- Underrun: write one sample 24'h000123, then stop → at the second frame start underrun=1 for exactly one cycle. Frame data is 0 with FIR_I2S_ZERO_FILL_EN defined, 0x000123 otherwise.
- Simultaneous pop and write on an empty FIFO → underrun pulses, and the written sample appears in the following frame.
- Reset asserted at bit_cnt=40 → next cycle all outputs at reset values; after a new sample is written, the first frame starts cleanly with lrck=0 and p=0.
